lsu_queue: RTL

// Parametrised in-order load/store unit; successor to the single-request MMU path. Computes
// src1+imm, queues up to DEPTH memory uops, and keeps several requests outstanding on a

---
 rtl/lsu_queue.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_queue.sv
// rtl/lsu_queue.sv - in-order load/store queue with split req/rsp memory bus
// Purpose: computes src1+imm, queues up to DEPTH memory uops, issues them in order
//          to a req/rsp bus with several requests outstanding, and retires results in
//          program order on a registered writeback port.
// Ports:   clk_i/reset_i (async, active-high); uop_* issue side with uop_ready_o and
//          mem_stall_o; mem_req_* request channel (valid/grant); mem_rsp_* response
//          channel (in request order); result_* one-cycle retire pulse with data/tag/err.
module lsu_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int IMM_WIDTH  = 12,
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    uop_valid_i,
  input  logic                    uop_is_load_i,
  input  logic                    uop_is_store_i,
  input  logic [2:0]              ctrl_mem_i,
  input  logic [DATA_WIDTH-1:0]   src1_i,
  input  logic [DATA_WIDTH-1:0]   src2_i,
  input  logic [IMM_WIDTH-1:0]    immediate_i,
  input  logic [TAG_WIDTH-1:0]    uop_tag_i,
  output logic                    uop_ready_o,
  output logic                    mem_stall_o,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_grant_i,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr_o,
  output logic                    mem_req_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_req_be_o,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata_o,
  input  logic                    mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata_i,
  input  logic                    mem_rsp_err_i,
  output logic                    result_valid_o,
  output logic [DATA_WIDTH-1:0]   result_data_o,
  output logic [TAG_WIDTH-1:0]    result_tag_o,
  output logic                    result_is_load_o,
  output logic                    result_err_o
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] ent_addr_q  [DEPTH];
  logic [1:0]            ent_size_q  [DEPTH];
  logic                  ent_sign_q  [DEPTH];
  logic                  ent_we_q    [DEPTH];
  logic                  ent_err_q   [DEPTH];
  logic [BE_W-1:0]       ent_be_q    [DEPTH];
  logic [DATA_WIDTH-1:0] ent_wdata_q [DEPTH];
  logic [TAG_WIDTH-1:0]  ent_tag_q   [DEPTH];

  // Entries head..iss-1 are on the bus (out_q of them); iss..tail-1 await issue.
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, iss_q, iss_d;
  logic [CNT_W-1:0] count_q, count_d, out_q, out_d;

  logic                  res_valid_q, res_valid_d, res_is_load_q, res_is_load_d;
  logic                  res_err_q, res_err_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [TAG_WIDTH-1:0]  res_tag_q, res_tag_d;

  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [1:0]            acc_size;
  logic [OFF_W-1:0]      acc_off;
  logic                  acc_bad;
  int                    acc_nbytes;
  logic [BE_W-1:0]       acc_be;
  logic [DATA_WIDTH-1:0] acc_wdata;

  logic [OFF_W-1:0]      head_off;
  logic [DATA_WIDTH-1:0] ld_shift, ld_ext;
  int                    ld_bits;
  logic                  ld_msb;

  logic full, accept, pending, iss_err, issue, err_retire, rsp_pop, pop;

  // Address generation, legality and lane placement for the incoming uop.
  always_comb begin
    acc_addr = src1_i[ADDR_WIDTH-1:0]
             + {{(ADDR_WIDTH-IMM_WIDTH){immediate_i[IMM_WIDTH-1]}}, immediate_i};
    acc_size = ctrl_mem_i[1:0];
    acc_off  = acc_addr[OFF_W-1:0];
    acc_bad  = (ctrl_mem_i == 3'b111) ||
               ((DATA_WIDTH == 32) && (ctrl_mem_i == 3'b011 || ctrl_mem_i == 3'b110));
    case (acc_size)
      2'd1:    acc_bad = acc_bad | acc_addr[0];
      2'd2:    acc_bad = acc_bad | (acc_addr[1:0] != 2'b00);
      2'd3:    acc_bad = acc_bad | (acc_addr[2:0] != 3'b000);
      default: acc_bad = acc_bad;
    endcase
    acc_nbytes = 1 << acc_size;
    for (int b = 0; b < BE_W; b++) begin
      acc_be[b] = (b >= int'(acc_off)) && (b < int'(acc_off) + acc_nbytes);
    end
    case (acc_size)
      2'd0:    acc_wdata = {BE_W{src2_i[7:0]}};
      2'd1:    acc_wdata = {(BE_W/2){src2_i[15:0]}};
      2'd2:    acc_wdata = {(DATA_WIDTH/32){src2_i[31:0]}};
      default: acc_wdata = src2_i;
    endcase
  end

  // Lane select and sign/zero extension of the response for the head entry.
  always_comb begin
    head_off = ent_addr_q[head_q][OFF_W-1:0];
    ld_shift = mem_rsp_rdata_i >> {head_off, 3'b000};
    ld_bits  = 8 << ent_size_q[head_q];
    case (ent_size_q[head_q])
      2'd0:    ld_msb = ld_shift[7];
      2'd1:    ld_msb = ld_shift[15];
      2'd2:    ld_msb = ld_shift[31];
      default: ld_msb = ld_shift[DATA_WIDTH-1];
    endcase
    for (int i = 0; i < DATA_WIDTH; i++) begin
      ld_ext[i] = (i < ld_bits) ? ld_shift[i] : (ent_sign_q[head_q] & ld_msb);
    end
  end

  always_comb begin
    full       = (count_q == CNT_W'(DEPTH));
    accept     = uop_valid_i & !full & (uop_is_load_i | uop_is_store_i);
    pending    = (count_q != out_q);
    iss_err    = ent_err_q[iss_q];
    issue      = pending & !iss_err & mem_req_grant_i;
    // A bad entry waits until everything ahead of it has retired, then retires itself.
    err_retire = pending & iss_err & (out_q == '0);
    rsp_pop    = mem_rsp_valid_i & (out_q != '0);
    pop        = rsp_pop | err_retire;

    tail_d  = accept ? tail_q + PTR_W'(1) : tail_q;
    head_d  = pop ? head_q + PTR_W'(1) : head_q;
    iss_d   = (issue | err_retire) ? iss_q + PTR_W'(1) : iss_q;
    count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
    out_d   = out_q + CNT_W'(issue) - CNT_W'(rsp_pop);

    res_valid_d   = pop;
    res_data_d    = res_data_q;
    res_tag_d     = res_tag_q;
    res_is_load_d = res_is_load_q;
    res_err_d     = res_err_q;
    if (pop) begin
      res_tag_d     = ent_tag_q[head_q];
      res_is_load_d = !ent_we_q[head_q];
      res_err_d     = err_retire | mem_rsp_err_i;
      res_data_d    = (err_retire || mem_rsp_err_i || ent_we_q[head_q]) ? '0 : ld_ext;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q        <= '0;
      tail_q        <= '0;
      iss_q         <= '0;
      count_q       <= '0;
      out_q         <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_tag_q     <= '0;
      res_is_load_q <= 1'b0;
      res_err_q     <= 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        ent_addr_q[e]  <= '0;
        ent_size_q[e]  <= '0;
        ent_sign_q[e]  <= 1'b0;
        ent_we_q[e]    <= 1'b0;
        ent_err_q[e]   <= 1'b0;
        ent_be_q[e]    <= '0;
        ent_wdata_q[e] <= '0;
        ent_tag_q[e]   <= '0;
      end
    end else begin
      if (accept) begin
        ent_addr_q[tail_q]  <= acc_addr;
        ent_size_q[tail_q]  <= acc_size;
        ent_sign_q[tail_q]  <= !ctrl_mem_i[2];
        ent_we_q[tail_q]    <= uop_is_store_i;
        ent_err_q[tail_q]   <= acc_bad;
        ent_be_q[tail_q]    <= acc_be;
        ent_wdata_q[tail_q] <= acc_wdata;
        ent_tag_q[tail_q]   <= uop_tag_i;
      end
      head_q        <= head_d;
      tail_q        <= tail_d;
      iss_q         <= iss_d;
      count_q       <= count_d;
      out_q         <= out_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_tag_q     <= res_tag_d;
      res_is_load_q <= res_is_load_d;
      res_err_q     <= res_err_d;
    end
  end

  assign uop_ready_o      = !full;
  assign mem_stall_o      = uop_valid_i & (uop_is_load_i | uop_is_store_i) & full;
  assign mem_req_valid_o  = pending & !iss_err;
  assign mem_req_addr_o   = {ent_addr_q[iss_q][ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_req_we_o     = ent_we_q[iss_q];
  assign mem_req_be_o     = ent_be_q[iss_q];
  assign mem_req_wdata_o  = ent_wdata_q[iss_q];
  assign result_valid_o   = res_valid_q;
  assign result_data_o    = res_data_q;
  assign result_tag_o     = res_tag_q;
  assign result_is_load_o = res_is_load_q;
  assign result_err_o     = res_err_q;

endmodule
